// File: rtl/vga_pkg.sv
// Shared VGA screen constants and position-controller state encodings.
package vga_pkg;
  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FALL = 2'd1,
    ST_RISE = 2'd2,
    ST_STOP = 2'd3
  } state_t;
endpackage

// File: rtl/draw_rect_ctl_if.sv
// Mouse/frame inputs and rectangle position outputs of draw_rect_ctl.
interface draw_rect_ctl_if;
  logic        vblnk_in;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] xpos;
  logic [11:0] ypos;

  modport master (output vblnk_in, mouse_left, mouse_xpos, mouse_ypos,
                  input  xpos, ypos);
  modport slave  (input  vblnk_in, mouse_left, mouse_xpos, mouse_ypos,
                  output xpos, ypos);
endinterface

// File: rtl/draw_rect_ctl_frame_tick.sv
// Rising-edge detector on vblnk: one-cycle tick per frame.
module frame_tick (
  input  logic pclk,
  input  logic rst,
  input  logic vblnk_in,
  output logic tick
);
  logic r_vblnk_d;

  // Reset value 0 makes a high vblnk at reset release count as a tick.
  always_ff @(posedge pclk or posedge rst)
    if (rst) r_vblnk_d <= 1'b0;
    else     r_vblnk_d <= vblnk_in;

  assign tick = vblnk_in & ~r_vblnk_d;
endmodule

// File: rtl/draw_rect_ctl.sv
// Rectangle position controller: follows the mouse, or drops and bounces
// the rectangle under gravity, updating once per frame at vblank start.
module draw_rect_ctl
  import vga_pkg::*;
#(
  parameter int SCREEN_HEIGHT = SCREEN_H,
  parameter int RECT_H        = 64,
  parameter int GRAVITY       = 1,
  parameter int VMAX          = 32,
  parameter int DAMP_SHIFT    = 1,
  parameter int VMIN          = 2
) (
  input  logic          pclk,
  input  logic          rst,
  draw_rect_ctl_if.slave bus
);
  localparam logic [11:0] FLOOR = 12'(SCREEN_HEIGHT - RECT_H);
  localparam logic [11:0] GRAV  = 12'(GRAVITY);
  localparam logic [12:0] VMX   = 13'(VMAX);
  localparam logic [11:0] VMN   = 12'(VMIN);

  logic        w_tick;
  state_t      r_state, w_state_nxt;
  logic [11:0] r_xpos, r_ypos, r_vel;
  logic [11:0] w_xpos_nxt, w_ypos_nxt, w_vel_nxt, w_v2;
  logic [12:0] w_sum, w_diff, w_vel_inc;
  logic        w_hit;

  frame_tick u_frame_tick (
    .pclk     (pclk),
    .rst      (rst),
    .vblnk_in (bus.vblnk_in),
    .tick     (w_tick)
  );

  // 13-bit sums catch floor overshoot and ceiling underflow.
  assign w_sum     = {1'b0, r_ypos} + {1'b0, r_vel};
  assign w_diff    = {1'b0, r_ypos} - {1'b0, r_vel};
  assign w_vel_inc = {1'b0, r_vel} + {1'b0, GRAV};
  assign w_v2      = r_vel - (r_vel >> DAMP_SHIFT);
  assign w_hit     = (w_sum >= {1'b0, FLOOR});

  always_ff @(posedge pclk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_tick && bus.mouse_left) w_state_nxt = ST_FALL;
      ST_FALL: if (w_tick && w_hit) w_state_nxt = (w_v2 < VMN) ? ST_STOP : ST_RISE;
      ST_RISE: if (w_tick && (r_vel <= GRAV)) w_state_nxt = ST_FALL;
      ST_STOP: if (w_tick && !bus.mouse_left) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_xpos_nxt = r_xpos;
    w_ypos_nxt = r_ypos;
    w_vel_nxt  = r_vel;
    case (r_state)
      ST_IDLE: begin
        w_xpos_nxt = bus.mouse_xpos;
        w_ypos_nxt = (bus.mouse_ypos > FLOOR) ? FLOOR : bus.mouse_ypos;
        w_vel_nxt  = 12'd0;
      end
      ST_FALL: if (w_tick) begin
        if (w_hit) begin
          w_ypos_nxt = FLOOR;
          w_vel_nxt  = (w_v2 < VMN) ? 12'd0 : w_v2;
        end else begin
          w_ypos_nxt = w_sum[11:0];
          w_vel_nxt  = (w_vel_inc > VMX) ? VMX[11:0] : w_vel_inc[11:0];
        end
      end
      ST_RISE: if (w_tick) begin
        w_ypos_nxt = w_diff[12] ? 12'd0 : w_diff[11:0];
        w_vel_nxt  = (r_vel <= GRAV) ? 12'd0 : r_vel - GRAV;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      r_xpos <= 12'd0;
      r_ypos <= 12'd0;
      r_vel  <= 12'd0;
    end else begin
      r_xpos <= w_xpos_nxt;
      r_ypos <= w_ypos_nxt;
      r_vel  <= w_vel_nxt;
    end

  assign bus.xpos = r_xpos;
  assign bus.ypos = r_ypos;
endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed bench for draw_rect_ctl: mouse tracking, drop/bounce trajectory,
// vblank edge detection and asynchronous reset.
module tb_draw_rect_ctl;
  logic pclk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 pclk = ~pclk;

  draw_rect_ctl_if bus ();

  draw_rect_ctl dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, ".x"}, 32'(bus.xpos), x);
    chk({tag, ".y"}, 32'(bus.ypos), y);
  endtask

  // One frame: vblnk high for one cycle; results visible at the next negedge.
  task automatic tick();
    @(negedge pclk) bus.vblnk_in = 1'b1;
    @(negedge pclk) bus.vblnk_in = 1'b0;
    @(negedge pclk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.vblnk_in   = 1'b0;
    bus.mouse_left = 1'b0;
    bus.mouse_xpos = 12'd55;
    bus.mouse_ypos = 12'd66;
    #22;
    chk_pos("reset", 0, 0);
    chk("reset.state", 32'(dut.r_state), 0);
    chk("reset.vel", 32'(dut.r_vel), 0);

    // IDLE tracking, one-cycle latency and floor clamp
    @(negedge pclk) rst = 1'b0;
    bus.mouse_xpos = 12'd100; bus.mouse_ypos = 12'd200;
    @(negedge pclk);
    chk_pos("track", 100, 200);
    bus.mouse_ypos = 12'd750;
    @(negedge pclk);
    chk("clamp750", 32'(bus.ypos), 704);
    bus.mouse_ypos = 12'd703;
    @(negedge pclk);
    chk("below_floor", 32'(bus.ypos), 703);

    // Click -> FALL from (300,0)
    bus.mouse_xpos = 12'd300; bus.mouse_ypos = 12'd0; bus.mouse_left = 1'b1;
    @(negedge pclk);
    tick();
    chk("click.state", 32'(dut.r_state), 1);
    chk_pos("click", 300, 0);
    chk("click.vel", 32'(dut.r_vel), 0);

    // Mouse moves and button toggles are ignored while falling
    bus.mouse_xpos = 12'd500; bus.mouse_ypos = 12'd100;
    for (int i = 0; i < 10; i++) begin
      bus.mouse_left = i[0];
      tick();
    end
    chk_pos("fall10", 300, 45);
    chk("fall10.vel", 32'(dut.r_vel), 10);
    chk("fall10.state", 32'(dut.r_state), 1);

    // Long vblank: exactly one update
    @(negedge pclk) bus.vblnk_in = 1'b1;
    repeat (3) @(negedge pclk);
    chk("hold.early", 32'(bus.ypos), 55);
    repeat (497) @(negedge pclk);
    chk("hold.late", 32'(bus.ypos), 55);
    chk("hold.vel", 32'(dut.r_vel), 11);
    bus.vblnk_in = 1'b0;
    @(negedge pclk);
    chk("hold.after", 32'(bus.ypos), 55);

    // Ticks 12..38: velocity saturates at 32
    ticks(27);
    chk("fall38.y", 32'(bus.ypos), 688);
    chk("fall38.vel", 32'(dut.r_vel), 32);

    // Impact: 688+32 >= 704 -> clamp, vel 32-16
    tick();
    chk("impact.y", 32'(bus.ypos), 704);
    chk("impact.vel", 32'(dut.r_vel), 16);
    chk("impact.state", 32'(dut.r_state), 2);
    tick();
    chk("rise1.y", 32'(bus.ypos), 688);
    chk("rise1.vel", 32'(dut.r_vel), 15);

    // Rise ends after subtracting 16+15+..+1 = 136
    ticks(15);
    chk("apex.y", 32'(bus.ypos), 568);
    chk("apex.state", 32'(dut.r_state), 1);
    chk("apex.vel", 32'(dut.r_vel), 0);

    // Second fall: impact on 17th tick, vel 16 -> 8
    ticks(17);
    chk("impact2.y", 32'(bus.ypos), 704);
    chk("impact2.vel", 32'(dut.r_vel), 8);
    chk("impact2.state", 32'(dut.r_state), 2);

    // Rise 8, fall 9, rise 4, fall 5, rise 2, fall 3 -> bounce 1 < 2 -> STOP
    bus.mouse_left = 1'b1;
    ticks(31);
    chk("stop.state", 32'(dut.r_state), 3);
    chk("stop.y", 32'(bus.ypos), 704);
    chk("stop.vel", 32'(dut.r_vel), 0);

    // Button still held: STOP persists
    tick();
    chk("stop_hold.state", 32'(dut.r_state), 3);
    chk_pos("stop_hold", 300, 704);

    // Release + tick -> IDLE, then outputs track mouse
    bus.mouse_left = 1'b0;
    tick();
    chk("idle.state", 32'(dut.r_state), 0);
    chk_pos("idle", 500, 100);

    // Reset mid-fall from (50,10): 5 ticks -> 10+0+1+2+3+4 = 20
    bus.mouse_xpos = 12'd50; bus.mouse_ypos = 12'd10; bus.mouse_left = 1'b1;
    @(negedge pclk);
    tick();
    ticks(5);
    chk("fall2.y", 32'(bus.ypos), 20);
    chk("fall2.state", 32'(dut.r_state), 1);
    @(negedge pclk);
    #2 rst = 1'b1;
    #1;
    chk_pos("async_rst", 0, 0);
    chk("async_rst.state", 32'(dut.r_state), 0);
    bus.mouse_left = 1'b0;
    @(negedge pclk) rst = 1'b0;
    @(negedge pclk);
    chk("post_rst.state", 32'(dut.r_state), 0);
    chk_pos("post_rst", 50, 10);

    // vblnk already high at reset release counts as a tick
    rst = 1'b1;
    bus.vblnk_in = 1'b1; bus.mouse_left = 1'b1;
    @(negedge pclk) rst = 1'b0;
    @(negedge pclk);
    chk("rel_tick.state", 32'(dut.r_state), 1);
    chk_pos("rel_tick", 50, 10);
    @(negedge pclk);
    chk("rel_tick.no_retick", 32'(dut.r_vel), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
